// File: rtl/lut_cfg_loader_pkg.sv
// Shared types and helpers for the 3D-LUT configuration loader.
// The optional checksum port is enabled by defining LUT_CFG_CHKSUM_EN.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  function automatic int unsigned n_entry(input int unsigned gs);
    return gs * gs * gs;
  endfunction

endpackage

// File: rtl/lut_cfg_loader_if.sv
// Host sample stream (s_*) and downstream cfg stream (cfg_*) of the LUT loader.
// master = host / sink side, slave = the loader itself.
interface lut_cfg_loader_if #(
  parameter int unsigned LUT_CD = 10
);
  logic [LUT_CD-1:0]   s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic [3*LUT_CD-1:0] cfg_data;
  logic                cfg_valid;
  logic                cfg_last;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, cfg_data, cfg_valid, cfg_last
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, cfg_data, cfg_valid, cfg_last
  );
endinterface

// File: rtl/lut_cfg_loader_pack.sv
// Channel counter plus R/G holding registers; presents the packed {B,G,R} entry
// combinationally alongside a strobe on the accepted B sample.
module lut_cfg_pack
  import lut_cfg_pkg::*;
#(
  parameter int unsigned LUT_CD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_accept,
  input  logic [LUT_CD-1:0]   i_data,
  output logic [3*LUT_CD-1:0] o_entry,
  output logic                o_entry_done
);

  logic [1:0]        r_ch;
  logic [LUT_CD-1:0] r_r;
  logic [LUT_CD-1:0] r_g;

  // Clear wins over accept so an aborted partial entry is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch <= CH_R;
      r_r  <= '0;
      r_g  <= '0;
    end else if (i_clear) begin
      r_ch <= CH_R;
      r_r  <= '0;
      r_g  <= '0;
    end else if (i_accept) begin
      unique case (r_ch)
        CH_R: begin
          r_r  <= i_data;
          r_ch <= CH_G;
        end
        CH_G: begin
          r_g  <= i_data;
          r_ch <= CH_B;
        end
        default: r_ch <= CH_R;
      endcase
    end
  end

  assign o_entry_done = i_accept && (r_ch == CH_B);
  assign o_entry      = {i_data, r_g, r_r};

endmodule

// File: rtl/lut_cfg_loader.sv
// 3D-LUT cfg stream source: packs host samples into {B,G,R} entries and always
// completes a full GS^3 sweep, zero-padding on abort. Optional: LUT_CFG_CHKSUM_EN.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int unsigned GS     = 33,
  parameter int unsigned LUT_CD = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  lut_cfg_loader_if.slave   bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
`ifdef LUT_CFG_CHKSUM_EN
  ,
  output logic [15:0]       o_chksum
`endif
);

  localparam int unsigned N_ENTRY = n_entry(GS);
  localparam int unsigned CNT_W   = $clog2(N_ENTRY);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ENTRY - 1);

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_cfg_valid, w_cfg_valid_d;
  logic                r_cfg_last, w_cfg_last_d;
  logic [3*LUT_CD-1:0] r_cfg_data, w_cfg_data_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;

  logic                w_ready;
  logic                w_accept;
  logic                w_clear;
  logic                w_at_last;
  logic                w_entry_done;
  logic [3*LUT_CD-1:0] w_entry;

  assign w_ready   = (r_state == StLoad);
  assign w_accept  = bus.s_valid && w_ready;
  assign w_at_last = (r_cnt == LAST_IDX);

  lut_cfg_pack #(
    .LUT_CD (LUT_CD)
  ) u_pack (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_data       (bus.s_data),
    .o_entry      (w_entry),
    .o_entry_done (w_entry_done)
  );

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_cfg_valid_d = 1'b0;
    w_cfg_last_d  = 1'b0;
    w_cfg_data_d  = '0;
    w_done_d      = 1'b0;
    w_err_d       = r_err;
    w_clear       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StLoad;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_clear   = 1'b1;
        end
      end

      StLoad: begin
        if (w_accept) begin
          if (w_entry_done) begin
            w_cfg_valid_d = 1'b1;
            w_cfg_data_d  = w_entry;
            w_cfg_last_d  = w_at_last;
            w_cnt_d       = r_cnt + 1'b1;
            if (w_at_last) begin
              w_done_d  = 1'b1;
              w_state_d = StIdle;
              if (!bus.s_last) w_err_d = 1'b1;
            end else if (bus.s_last) begin
              w_err_d   = 1'b1;
              w_state_d = StFlush;
            end
          end else if (bus.s_last) begin
            // Early last on R or G: drop the half-built entry and pad the rest.
            w_err_d   = 1'b1;
            w_clear   = 1'b1;
            w_state_d = StFlush;
          end
        end
      end

      StFlush: begin
        w_cfg_valid_d = 1'b1;
        w_cfg_last_d  = w_at_last;
        w_cnt_d       = r_cnt + 1'b1;
        if (w_at_last) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_last  <= 1'b0;
      r_cfg_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_cfg_valid <= w_cfg_valid_d;
      r_cfg_last  <= w_cfg_last_d;
      r_cfg_data  <= w_cfg_data_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
    end
  end

`ifdef LUT_CFG_CHKSUM_EN
  logic [15:0] r_chksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chksum <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_chksum <= '0;
    end else if (w_accept) begin
      r_chksum <= r_chksum + 16'(bus.s_data);
    end
  end

  assign o_chksum = r_chksum;
`endif

  assign bus.s_ready   = w_ready;
  assign bus.cfg_valid = r_cfg_valid;
  assign bus.cfg_last  = r_cfg_last;
  assign bus.cfg_data  = r_cfg_data;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader at GS=17; covers checksum when LUT_CFG_CHKSUM_EN is set.
module tb_lut_cfg_loader;

  localparam int unsigned GS     = 17;
  localparam int unsigned LUT_CD = 10;
  localparam int          N      = 4913;
  localparam int          NS     = 3 * N;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic o_busy, o_done, o_err;
`ifdef LUT_CFG_CHKSUM_EN
  logic [15:0] o_chksum;
`endif

  lut_cfg_loader_if #(.LUT_CD(LUT_CD)) bus ();

  lut_cfg_loader #(
    .GS     (GS),
    .LUT_CD (LUT_CD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .bus      (bus),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
`ifdef LUT_CFG_CHKSUM_EN
    ,
    .o_chksum (o_chksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Beat monitor: statistics consumed by the directed steps below.
  logic mon_clr;
  int   exp_n_data;
  int   mon_beats, mon_data_err, mon_last_cnt, mon_last_idx;
  int   mon_done_cnt, mon_done_wo_last, mon_inv;

  function automatic logic [29:0] exp_entry(input int idx, input int ndata);
    logic [9:0] r, g, b;
    if (idx >= ndata) return '0;
    r = 10'((3 * idx) % 1024);
    g = 10'((3 * idx + 1) % 1024);
    b = 10'((3 * idx + 2) % 1024);
    return {b, g, r};
  endfunction

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_beats = 0; mon_data_err = 0; mon_last_cnt = 0; mon_last_idx = -1;
      mon_done_cnt = 0; mon_done_wo_last = 0; mon_inv = 0;
    end else begin
      if (bus.cfg_last && !bus.cfg_valid) mon_inv++;
      if (bus.cfg_valid) begin
        if (bus.cfg_data !== exp_entry(mon_beats, exp_n_data)) mon_data_err++;
        if (bus.cfg_last) begin
          mon_last_cnt++;
          mon_last_idx = mon_beats;
        end
        mon_beats++;
      end
      if (o_done) begin
        mon_done_cnt++;
        if (!bus.cfg_last) mon_done_wo_last++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic send_sample(input int k, input bit last, input bit stall);
    logic rdy;
    int   tries;
    if (stall && ($urandom_range(0, 3) == 0)) begin
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.s_data  = 10'(k % 1024);
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    tries = 0;
    forever begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 50) begin
        check("ready_timeout", 64'(tries), 64'(0));
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic run_samples(input int n, input int last_at, input bit stall);
    for (int k = 0; k < n; k++) send_sample(k, (k == last_at), stall);
  endtask

  task automatic check_load(input string tag, input logic exp_err);
    int i;
    i = 0;
    while (mon_done_cnt == 0 && i < 20000) begin
      @(posedge clk);
      #1;
      i++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_cnt"},  64'(mon_done_cnt), 64'(1));
    check({tag, "_beats"},     64'(mon_beats), 64'(N));
    check({tag, "_data_err"},  64'(mon_data_err), 64'(0));
    check({tag, "_last_cnt"},  64'(mon_last_cnt), 64'(1));
    check({tag, "_last_idx"},  64'(mon_last_idx), 64'(N - 1));
    check({tag, "_done_wo_last"}, 64'(mon_done_wo_last), 64'(0));
    check({tag, "_last_no_valid"}, 64'(mon_inv), 64'(0));
    check({tag, "_err"},       64'(o_err), 64'(exp_err));
    check({tag, "_busy"},      64'(o_busy), 64'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(o_busy), 64'(0));
    check({tag, "_done"},      64'(o_done), 64'(0));
    check({tag, "_err"},       64'(o_err), 64'(0));
    check({tag, "_ready"},     64'(bus.s_ready), 64'(0));
    check({tag, "_cfg_valid"}, 64'(bus.cfg_valid), 64'(0));
    check({tag, "_cfg_last"},  64'(bus.cfg_last), 64'(0));
    check({tag, "_cfg_data"},  64'(bus.cfg_data), 64'(0));
`ifdef LUT_CFG_CHKSUM_EN
    check({tag, "_chksum"},    64'(o_chksum), 64'(0));
`endif
  endtask

  initial begin
    logic [15:0] exp_sum;
    exp_sum = '0;
    for (int k = 0; k < NS; k++) exp_sum = exp_sum + 16'(k % 1024);

    rst = 1'b1; i_start = 1'b0; mon_clr = 1'b1; exp_n_data = 0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    mon_clr = 1'b0;

    // Clean load.
    clear_mon();
    exp_n_data = N;
    pulse_start();
    check("clean_ready", 64'(bus.s_ready), 64'(1));
    check("clean_busy_start", 64'(o_busy), 64'(1));
    run_samples(NS, NS - 1, 1'b0);
    check_load("clean", 1'b0);
`ifdef LUT_CFG_CHKSUM_EN
    check("clean_chksum", 64'(o_chksum), 64'(exp_sum));
`endif

    // Abort with last on the B of entry 99.
    clear_mon();
    exp_n_data = 100;
    pulse_start();
    run_samples(300, 299, 1'b0);
    check("abort_flush_ready", 64'(bus.s_ready), 64'(0));
    check("abort_flush_busy", 64'(o_busy), 64'(1));
    check_load("abort", 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_err_sticky", 64'(o_err), 64'(1));

    // Abort with last on the G of entry 100; start also clears the sticky error.
    clear_mon();
    exp_n_data = 100;
    pulse_start();
    check("partial_err_cleared", 64'(o_err), 64'(0));
    run_samples(302, 301, 1'b0);
    check_load("partial", 1'b1);

    // Full table without last: completes normally but flags an error.
    clear_mon();
    exp_n_data = N;
    pulse_start();
    run_samples(NS, -1, 1'b0);
    check_load("nolast", 1'b1);
    bus.s_valid = 1'b1;
    @(negedge clk);
    check("extra_sample_ready", 64'(bus.s_ready), 64'(0));
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("extra_sample_no_beat", 64'(mon_beats), 64'(N));

    // Reset after 50 entries, then a stalled clean load.
    clear_mon();
    exp_n_data = N;
    pulse_start();
    run_samples(150, -1, 1'b0);
    check("midload_valid_before_rst", 64'(bus.cfg_valid), 64'(1));
    rst = 1'b1;
    #1;
    check_idle_outputs("midload_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    pulse_start();
    check("stall_err_after_start", 64'(o_err), 64'(0));
    run_samples(NS, NS - 1, 1'b1);
    check_load("stall", 1'b0);
`ifdef LUT_CFG_CHKSUM_EN
    check("stall_chksum", 64'(o_chksum), 64'(exp_sum));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
